// File: rtl/rx_bit_timer_ctrl_if.sv
// Signal bundle between the receive bit-timing controller, its external
// 4-bit flex counter and the downstream shift register / receive FIFO.
interface rx_bit_timer_ctrl_if;
  logic       ctr_rollover_flag;
  logic       ctr_clear;
  logic       ctr_count_enable;
  logic [3:0] ctr_rollover_val;
  logic       shift_strobe;
  logic       sample_bit;
  logic       frame_done;
  logic       framing_error;

  modport master (
    input  ctr_rollover_flag,
    output ctr_clear,
    output ctr_count_enable,
    output ctr_rollover_val,
    output shift_strobe,
    output sample_bit,
    output frame_done,
    output framing_error
  );

  modport slave (
    output ctr_rollover_flag,
    input  ctr_clear,
    input  ctr_count_enable,
    input  ctr_rollover_val,
    input  shift_strobe,
    input  sample_bit,
    input  frame_done,
    input  framing_error
  );
endinterface

// File: rtl/rx_bit_timer_ctrl.sv
// Receive bit-timing controller: synchronizes the serial line, qualifies the
// start bit and paces mid-bit sampling through an external 4-bit flex counter.
module rx_bit_timer_ctrl #(
  parameter int BIT_PERIOD = 10,
  parameter int DATA_BITS  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial_in,
  rx_bit_timer_ctrl_if.master bus
);

  localparam int         HALF_INT   = ((BIT_PERIOD / 2) < 1) ? 1 : (BIT_PERIOD / 2);
  localparam logic [3:0] HALF_VAL   = 4'(HALF_INT);
  localparam logic [3:0] PERIOD_VAL = 4'(BIT_PERIOD);
  localparam logic [3:0] LAST_BIT   = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_CHK = 3'd1,
    ST_DATA_CLR  = 3'd2,
    ST_DATA      = 3'd3,
    ST_STOP      = 3'd4
  } state_t;

  state_t     state_r;
  state_t     next_state_s;
  logic [3:0] bit_cnt_r;
  logic       s_meta_r;
  logic       s_sync_r;
  logic       s_prev_r;
  logic       start_edge_s;
  logic       flag_s;
  logic       ctr_clear_r;
  logic       ctr_count_enable_r;
  logic [3:0] ctr_rollover_val_r;
  logic       shift_strobe_r;
  logic       sample_bit_r;
  logic       frame_done_r;
  logic       framing_error_r;

  // Counter controls are a pure function of the state: {clear, enable, rollover_val}.
  function automatic logic [5:0] ctr_decode(input state_t st);
    logic [5:0] res;
    case (st)
      ST_IDLE:      res = {1'b1, 1'b0, HALF_VAL};
      ST_START_CHK: res = {1'b0, 1'b1, HALF_VAL};
      ST_DATA_CLR:  res = {1'b1, 1'b0, PERIOD_VAL};
      ST_DATA:      res = {1'b0, 1'b1, PERIOD_VAL};
      ST_STOP:      res = {1'b0, 1'b1, PERIOD_VAL};
      default:      res = {1'b1, 1'b0, HALF_VAL};
    endcase
    return res;
  endfunction

  assign start_edge_s = s_prev_r & ~s_sync_r;
  assign flag_s       = bus.ctr_rollover_flag;

  // Two-flop synchronizer plus one history flop for falling-edge detection; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_meta_r <= 1'b1;
      s_sync_r <= 1'b1;
      s_prev_r <= 1'b1;
    end else begin
      s_meta_r <= serial_in;
      s_sync_r <= s_meta_r;
      s_prev_r <= s_sync_r;
    end
  end

  // Next-state selection; the line only matters at flag (mid-bit) instants.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) begin
          next_state_s = ST_START_CHK;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_START_CHK: begin
        if (flag_s) begin
          next_state_s = s_sync_r ? ST_IDLE : ST_DATA_CLR;
        end else begin
          next_state_s = ST_START_CHK;
        end
      end
      ST_DATA_CLR: begin
        next_state_s = ST_DATA;
      end
      ST_DATA: begin
        if (flag_s && (bit_cnt_r == LAST_BIT)) begin
          next_state_s = ST_STOP;
        end else begin
          next_state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (flag_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_STOP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, registered counter controls and registered datapath strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r            <= ST_IDLE;
      bit_cnt_r          <= 4'd0;
      ctr_clear_r        <= 1'b1;
      ctr_count_enable_r <= 1'b0;
      ctr_rollover_val_r <= HALF_VAL;
      shift_strobe_r     <= 1'b0;
      sample_bit_r       <= 1'b0;
      frame_done_r       <= 1'b0;
      framing_error_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      {ctr_clear_r, ctr_count_enable_r, ctr_rollover_val_r} <= ctr_decode(next_state_s);
      shift_strobe_r <= 1'b0;
      frame_done_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // START_CHK is only ever entered from here, so this is its entry point.
          if (start_edge_s) begin
            framing_error_r <= 1'b0;
          end
        end
        ST_START_CHK: begin
          if (flag_s && !s_sync_r) begin
            bit_cnt_r <= 4'd0;
          end
        end
        ST_DATA: begin
          if (flag_s) begin
            shift_strobe_r <= 1'b1;
            sample_bit_r   <= s_sync_r;
            bit_cnt_r      <= bit_cnt_r + 4'd1;
          end
        end
        ST_STOP: begin
          if (flag_s) begin
            frame_done_r    <= 1'b1;
            framing_error_r <= ~s_sync_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ctr_clear        = ctr_clear_r;
  assign bus.ctr_count_enable = ctr_count_enable_r;
  assign bus.ctr_rollover_val = ctr_rollover_val_r;
  assign bus.shift_strobe     = shift_strobe_r;
  assign bus.sample_bit       = sample_bit_r;
  assign bus.frame_done       = frame_done_r;
  assign bus.framing_error    = framing_error_r;

endmodule

// File: tb/tb_rx_bit_timer_ctrl.sv
// Scoreboard bench: two controller instances (P=10/8 bits and P=15/1 bit), each
// closed around a behavioural flex-counter model, driven with serial frames.
module tb_rx_bit_timer_ctrl;

  typedef struct {
    int inst;
    int kind;   // 0 = shift strobe, 1 = frame done
    int val;    // sample_bit or framing_error
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_a = 1'b1;
  logic serial_b = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  logic [3:0] cnt_a = 4'd0;
  logic [3:0] cnt_b = 4'd0;
  logic       flag_a = 1'b0;
  logic       flag_b = 1'b0;

  rx_bit_timer_ctrl_if ifa ();
  rx_bit_timer_ctrl_if ifb ();

  assign ifa.ctr_rollover_flag = flag_a;
  assign ifb.ctr_rollover_flag = flag_b;

  rx_bit_timer_ctrl #(.BIT_PERIOD(10), .DATA_BITS(8)) dut_a (
    .clk(clk), .rst(rst), .serial_in(serial_a), .bus(ifa)
  );
  rx_bit_timer_ctrl #(.BIT_PERIOD(15), .DATA_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .serial_in(serial_b), .bus(ifb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External flex counter: clear wins, wrap to 1 after rollover_val, flag registered.
  function automatic logic [3:0] ctr_next(input logic clr, input logic en,
                                          input logic [3:0] val, input logic [3:0] cnt);
    if (clr) return 4'd0;
    if (!en) return cnt;
    if (cnt == val) return 4'd1;
    return cnt + 4'd1;
  endfunction

  always @(posedge clk) begin
    cnt_a  <= ctr_next(ifa.ctr_clear, ifa.ctr_count_enable, ifa.ctr_rollover_val, cnt_a);
    flag_a <= (ctr_next(ifa.ctr_clear, ifa.ctr_count_enable, ifa.ctr_rollover_val, cnt_a)
               == ifa.ctr_rollover_val);
    cnt_b  <= ctr_next(ifb.ctr_clear, ifb.ctr_count_enable, ifb.ctr_rollover_val, cnt_b);
    flag_b <= (ctr_next(ifb.ctr_clear, ifb.ctr_count_enable, ifb.ctr_rollover_val, cnt_b)
               == ifb.ctr_rollover_val);
  end

  // {clear, enable, val[3:0], strobe, sample, done, ferr}
  function automatic logic [9:0] outs(input int inst);
    if (inst == 0)
      return {ifa.ctr_clear, ifa.ctr_count_enable, ifa.ctr_rollover_val,
              ifa.shift_strobe, ifa.sample_bit, ifa.frame_done, ifa.framing_error};
    return {ifb.ctr_clear, ifb.ctr_count_enable, ifb.ctr_rollover_val,
            ifb.shift_strobe, ifb.sample_bit, ifb.frame_done, ifb.framing_error};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int inst, input int kind, input int val, input int at);
    ev_t e;
    e.inst = inst;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int inst);
    logic [9:0] o;
    ev_t e;
    o = outs(inst);
    if (o[3] && o[1]) begin
      chk("strobe_done_overlap", 1, 0);
    end else if (o[3] || o[1]) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_instance", inst, e.inst);
        chk("event_kind", o[1] ? 1 : 0, e.kind);
        chk("event_cycle", cyc, e.cyc);
        if (e.kind == 1) chk("framing_error", int'(o[0]), e.val);
        else             chk("sample_bit", int'(o[2]), e.val);
      end
    end
  endtask

  // Monitor: flags overdue expectations, then matches each presented event.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missing_event_at", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      observe(0);
      observe(1);
    end
  end

  task automatic set_line(input int inst, input logic v);
    if (inst == 0) serial_a = v;
    else           serial_b = v;
  endtask

  task automatic chk_reset(input int inst, input int half);
    logic [9:0] o;
    o = outs(inst);
    chk("rst_ctr_clear", int'(o[9]), 1);
    chk("rst_ctr_enable", int'(o[8]), 0);
    chk("rst_ctr_val", int'(o[7:4]), half);
    chk("rst_strobe", int'(o[3]), 0);
    chk("rst_sample_bit", int'(o[2]), 0);
    chk("rst_frame_done", int'(o[1]), 0);
    chk("rst_framing_error", int'(o[0]), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One frame: start bit, data LSB first, stop bit, each p cycles; then gap idle cycles.
  task automatic send_frame(input int inst, input logic [7:0] data, input logic stop,
                            input int gap, input bit abort);
    int p, db, half, n, c, e_cyc, first;
    logic [9:0] o;
    logic v;
    p    = (inst == 0) ? 10 : 15;
    db   = (inst == 0) ? 8 : 1;
    half = p / 2;
    n    = (db + 2) * p;
    c    = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        c     = cyc;
        e_cyc = c + 2;
        first = e_cyc + half + p + 4;
        for (int k = 0; k < db; k++) begin
          if (!abort || (first + k * p) < e_cyc + 41)
            push_ev(inst, 0, int'(data[k]), first + k * p);
        end
        if (!abort) push_ev(inst, 1, stop ? 0 : 1, first + db * p);
      end
      o = outs(inst);
      if (i == 3) begin
        chk("startchk_enable", int'(o[8]), 1);
        chk("startchk_ferr_cleared", int'(o[0]), 0);
      end
      if (i == 4 + half) chk("dataclr_clear", int'(o[9]), 1);
      if (i == 5 + half && !(abort && i >= 43)) begin
        chk("data_enable", int'(o[8]), 1);
        chk("data_val", int'(o[7:4]), p);
      end
      if (abort && i == 42) rst = 1'b1;
      if (abort && i == 43) begin
        chk_reset(inst, half);
        rst = 1'b0;
      end
      if (i < p)                v = 1'b0;
      else if (i < (db + 1) * p) v = data[i / p - 1];
      else                      v = stop;
      set_line(inst, v);
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      set_line(inst, 1'b1);
    end
  endtask

  // Start bit shorter than the mid-start check: controller must fall back to idle silently.
  task automatic glitch(input int inst, input int len);
    int p, half;
    logic [9:0] o;
    p    = (inst == 0) ? 10 : 15;
    half = p / 2;
    for (int i = 0; i < half + 6; i++) begin
      @(negedge clk);
      o = outs(inst);
      if (i == 3 + half) chk("glitch_startchk_clear", int'(o[9]), 0);
      if (i == 4 + half) begin
        chk("glitch_back_idle_clear", int'(o[9]), 1);
        chk("glitch_back_idle_val", int'(o[7:4]), half);
      end
      if (i == 5 + half) chk("glitch_stays_idle", int'(o[9]), 1);
      set_line(inst, (i < len) ? 1'b0 : 1'b1);
    end
    idle(p);
  endtask

  initial begin
    logic [7:0] d;
    logic       s;
    int         g;
    logic [9:0] o;

    repeat (3) @(negedge clk);
    chk_reset(0, 5);
    chk_reset(1, 7);
    rst = 1'b0;
    idle(5);

    send_frame(0, 8'hA5, 1'b1, 6, 1'b0);
    glitch(0, 3);
    send_frame(0, 8'hFF, 1'b0, 10, 1'b0);
    o = outs(0);
    chk("ferr_held_until_start", int'(o[0]), 1);
    send_frame(0, 8'h3C, 1'b1, 0, 1'b0);
    send_frame(0, 8'hC3, 1'b1, 6, 1'b0);
    send_frame(0, 8'hFD, 1'b1, 8, 1'b1);
    send_frame(0, 8'h96, 1'b1, 5, 1'b0);

    for (int r = 0; r < 12; r++) begin
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      g = $urandom_range(0, 12);
      if (!s && g < 3) g = 3;
      send_frame(0, d, s, g, 1'b0);
      if (r % 4 == 3) glitch(0, $urandom_range(1, 6));
    end

    send_frame(1, 8'h01, 1'b1, 5, 1'b0);
    send_frame(1, 8'h00, 1'b0, 5, 1'b0);
    send_frame(1, 8'h01, 1'b1, 0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      d = 8'($urandom_range(0, 1));
      s = ($urandom_range(0, 1) != 0);
      send_frame(1, d, s, s ? $urandom_range(0, 4) : 4, 1'b0);
    end
    glitch(1, $urandom_range(1, 8));

    for (int t = 0; t < 400 && exp_q.size() > 0; t++) @(negedge clk);
    chk("pending_expectations", exp_q.size(), 0);
    idle(30);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_bit_timer_ctrl.md
# rx_bit_timer_ctrl

Bit-timing controller for the serial receive path. It synchronizes a raw serial line, detects a start bit, and drives the team's external 4-bit flex counter (clear, count_enable, rollover_val), consuming its rollover_flag to place sample points at mid-bit. It emits one shift strobe per data bit, plus frame-done and framing-error indications for the downstream shift register and receive FIFO.

## Interface
- BIT_PERIOD, 10, clocks per serial bit; legal range 2..15 (fits the 4-bit counter).
- DATA_BITS, 8, data bits per frame; legal range 1..15.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- serial_in  in  1  raw asynchronous serial line; idle high, start bit low, stop bit high.
- ctr_rollover_flag  in  1  rollover_flag from the 4-bit flex counter.
- ctr_clear  out  1  drives counter clear.
- ctr_count_enable  out  1  drives counter count_enable.
- ctr_rollover_val  out  4  drives counter rollover_val.
- shift_strobe  out  1  one-cycle pulse: sample_bit is valid and should be shifted in.
- sample_bit  out  1  synchronized line value captured at mid-bit.
- frame_done  out  1  one-cycle pulse at the end of the stop-bit sample.
- framing_error  out  1  set when the stop bit is sampled low; held until the next start detect.

## Operation
- Synchronizer: two flops (s_meta, s_sync) followed by s_prev. All three reset to 1.
- Start edge: s_prev=1 and s_sync=0 in the same cycle. E denotes that cycle.
- HALF = BIT_PERIOD/2, truncated, minimum 1.
- Counter model relied on: clear has priority and sets the count to 0. Each enabled cycle increments the count. The count wraps to 1 after reaching rollover_val. The flag is registered and is high exactly while count == rollover_val.
- FSM states. Counter outputs are decoded from the state only (Moore):
  - IDLE: clear=1, enable=0, val=HALF. Moves to START_CHK on a start edge.
  - START_CHK: clear=0, enable=1, val=HALF. When the flag is seen: if s_sync=0, go to DATA_CLR and clear bit_cnt; if s_sync=1, treat it as a glitch and go to IDLE with no output activity.
  - DATA_CLR: clear=1, enable=0, val=BIT_PERIOD. Lasts one cycle, then goes to DATA.
  - DATA: clear=0, enable=1, val=BIT_PERIOD. On each flag: register shift_strobe=1 and sample_bit=s_sync for the next cycle, then increment bit_cnt. When the flag arrives with bit_cnt==DATA_BITS-1, go to STOP.
  - STOP: clear=0, enable=1, val=BIT_PERIOD. On the flag: register frame_done=1 and framing_error=~s_sync, then go to IDLE.
- bit_cnt is 4 bits wide.
- shift_strobe, sample_bit, frame_done and framing_error are registered.
- framing_error clears on entry to START_CHK.
- Transitions on serial_in during DATA and STOP are ignored; only mid-bit samples matter.
- A new start edge is accepted in the first IDLE cycle after STOP. Back-to-back frames must be received with no loss.

## Timing
- Reset values:
  - state IDLE, bit_cnt 0.
  - ctr_clear 1, ctr_count_enable 0, ctr_rollover_val HALF.
  - shift_strobe 0, sample_bit 0, frame_done 0, framing_error 0.
- Input latency: s_sync lags serial_in by 2 cycles.
- Start check: the START_CHK flag occurs in cycle E+1+HALF.
- Data strobes: the first shift_strobe is high in cycle E+HALF+BIT_PERIOD+4. Subsequent strobes are exactly BIT_PERIOD cycles apart.
- End of frame: frame_done is high BIT_PERIOD cycles after the last shift_strobe.
- Defaults (P=10, HALF=5, 8 bits): strobes at E+19, E+29, ... E+89; frame_done at E+99.
- Every strobe and frame_done is exactly one cycle wide. They are never asserted in the same cycle.
- rst asserted in any state, including mid-frame: at the next edge, all outputs take their reset values and bit_cnt clears. No strobe or frame_done is emitted for the aborted frame.

## Test plan
- Frame 0xA5 (LSB first), P=10, clean stop: exactly 8 strobes, with sample_bit sequence 1,0,1,0,0,1,0,1 at E+19+10k. frame_done at E+99, framing_error=0.
- Glitch: serial_in low for 3 cycles, then high. FSM returns to IDLE at E+7; zero strobes, no frame_done.
- Stop bit held low, data 0xFF: 8 strobes with sample_bit=1, then frame_done with framing_error=1. framing_error stays 1 until the next start edge, then returns to 0.
- Back-to-back frames 0x3C then 0xC3 with no idle gap: 16 strobes with correct bits and two frame_done pulses, each error-free.
- rst pulsed at E+40 mid-frame: outputs return to reset values the next cycle, no further strobes, and the next frame is received correctly.
- BIT_PERIOD=15, DATA_BITS=1, frame bit 1: strobe at E+7+15+4=E+26 with sample_bit=1; frame_done at E+41.
